// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : voice_alloc
//  Purpose  : Polyphonic voice allocator between the MIDI event decoder and a
//             bank of VOICES nco instances. Each accepted event is resolved by
//             a sequential scan of the voice table (one voice per cycle)
//             followed by a single commit cycle. When every voice is busy a
//             note-on steals the oldest active voice.
//  Ports    :
//    clk, rst_n        clock, asynchronous active-low reset
//    ev_valid/ev_ready event handshake (transfer on valid && ready)
//    ev_type           00 note-off, 01 note-on, 10 program change,
//                      11 all-notes-off
//    ev_note, ev_vel   note number (program number for type 10), velocity
//    voice_note        per-voice note number, voice i at [7i+6:7i]
//    voice_vel         per-voice velocity, same packing
//    voice_ce          per-voice nco clock enable (voice active bit)
//    program_num       shared program for all nco instances
//    steal             one-cycle pulse after a note-on stole an active voice
//  Revision : 1.0  initial release
// ============================================================================
module voice_alloc #(
   parameter int VOICES = 4,
   parameter int AGE_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ev_valid,
   output logic                  ev_ready,
   input  logic [1:0]            ev_type,
   input  logic [6:0]            ev_note,
   input  logic [6:0]            ev_vel,
   output logic [7*VOICES-1:0]   voice_note,
   output logic [7*VOICES-1:0]   voice_vel,
   output logic [VOICES-1:0]     voice_ce,
   output logic [6:0]            program_num,
   output logic                  steal
);

   localparam int               IDX_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = '1;

   localparam logic [1:0] EV_OFF  = 2'b00;
   localparam logic [1:0] EV_ON   = 2'b01;
   localparam logic [1:0] EV_PROG = 2'b10;
   localparam logic [1:0] EV_ANO  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [1:0]                   type_q, type_d;
   logic [6:0]                   enote_q, enote_d;
   logic [6:0]                   evel_q, evel_d;

   // scan candidates
   logic                         match_found_q, match_found_d;
   logic [IDX_W-1:0]             match_idx_q, match_idx_d;
   logic                         free_found_q, free_found_d;
   logic [IDX_W-1:0]             free_idx_q, free_idx_d;
   logic                         old_found_q, old_found_d;
   logic [IDX_W-1:0]             old_idx_q, old_idx_d;
   logic [AGE_W-1:0]             old_age_q, old_age_d;

   // voice table
   logic [VOICES-1:0][6:0]       note_q, note_d;
   logic [VOICES-1:0][6:0]       vel_q, vel_d;
   logic [VOICES-1:0]            active_q, active_d;
   logic [VOICES-1:0][AGE_W-1:0] age_q, age_d;
   logic [6:0]                   program_q, program_d;
   logic                         steal_q, steal_d;

   logic [IDX_W-1:0]             target;
   logic                         is_note_on;
   logic                         is_note_off;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      type_d        = type_q;
      enote_d       = enote_q;
      evel_d        = evel_q;
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      free_found_d  = free_found_q;
      free_idx_d    = free_idx_q;
      old_found_d   = old_found_q;
      old_idx_d     = old_idx_q;
      old_age_d     = old_age_q;
      note_d        = note_q;
      vel_d         = vel_q;
      active_d      = active_q;
      age_d         = age_q;
      program_d     = program_q;
      steal_d       = 1'b0;
      target        = '0;

      // A note-on with zero velocity is a note-off by MIDI convention.
      is_note_on  = (type_q == EV_ON) && (evel_q != 7'd0);
      is_note_off = (type_q == EV_OFF) || ((type_q == EV_ON) && (evel_q == 7'd0));

      case (state_q)
         IDLE: begin
            if (ev_valid) begin
               state_d       = SCAN;
               idx_d         = '0;
               type_d        = ev_type;
               enote_d       = ev_note;
               evel_d        = ev_vel;
               match_found_d = 1'b0;
               free_found_d  = 1'b0;
               old_found_d   = 1'b0;
               match_idx_d   = '0;
               free_idx_d    = '0;
               old_idx_d     = '0;
               old_age_d     = '0;
            end
         end

         SCAN: begin
            if (active_q[idx_q]) begin
               if (!match_found_q && (note_q[idx_q] == enote_q)) begin
                  match_found_d = 1'b1;
                  match_idx_d   = idx_q;
               end
               // Strict compare keeps the lowest index on equal ages.
               if (!old_found_q || (age_q[idx_q] > old_age_q)) begin
                  old_found_d = 1'b1;
                  old_idx_d   = idx_q;
                  old_age_d   = age_q[idx_q];
               end
            end else if (!free_found_q) begin
               free_found_d = 1'b1;
               free_idx_d   = idx_q;
            end

            if (idx_q == LAST_IDX) begin
               state_d = COMMIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         COMMIT: begin
            state_d = IDLE;
            if (is_note_on) begin
               if (match_found_q) begin
                  target = match_idx_q;
               end else if (free_found_q) begin
                  target = free_idx_q;
               end else begin
                  // No free voice implies all voices active, so oldest exists.
                  target  = old_idx_q;
                  steal_d = 1'b1;
               end
               for (int i = 0; i < VOICES; i++) begin
                  if (IDX_W'(i) == target) begin
                     note_d[i]   = enote_q;
                     vel_d[i]    = evel_q;
                     active_d[i] = 1'b1;
                     age_d[i]    = '0;
                  end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                     age_d[i] = age_q[i] + 1'b1;
                  end
               end
            end else if (is_note_off) begin
               for (int i = 0; i < VOICES; i++) begin
                  if (active_q[i] && (note_q[i] == enote_q)) begin
                     active_d[i] = 1'b0;
                     vel_d[i]    = 7'd0;
                  end
               end
            end else if (type_q == EV_PROG) begin
               program_d = enote_q;
            end else if (type_q == EV_ANO) begin
               active_d = '0;
               vel_d    = '0;
               age_d    = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         type_q        <= 2'b00;
         enote_q       <= 7'd0;
         evel_q        <= 7'd0;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         free_found_q  <= 1'b0;
         free_idx_q    <= '0;
         old_found_q   <= 1'b0;
         old_idx_q     <= '0;
         old_age_q     <= '0;
         note_q        <= '0;
         vel_q         <= '0;
         active_q      <= '0;
         age_q         <= '0;
         program_q     <= 7'd0;
         steal_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         type_q        <= type_d;
         enote_q       <= enote_d;
         evel_q        <= evel_d;
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         free_found_q  <= free_found_d;
         free_idx_q    <= free_idx_d;
         old_found_q   <= old_found_d;
         old_idx_q     <= old_idx_d;
         old_age_q     <= old_age_d;
         note_q        <= note_d;
         vel_q         <= vel_d;
         active_q      <= active_d;
         age_q         <= age_d;
         program_q     <= program_d;
         steal_q       <= steal_d;
      end
   end

   assign ev_ready    = (state_q == IDLE);
   assign voice_note  = note_q;
   assign voice_vel   = vel_q;
   assign voice_ce    = active_q;
   assign program_num = program_q;
   assign steal       = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_alloc
//  Purpose  : Self-checking bench for voice_alloc (VOICES=4, AGE_W=8) using a
//             table of directed events with hand-computed expected voice state,
//             plus sequences for reset mid-scan and back-to-back handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_voice_alloc;

   localparam int VOICES = 4;
   localparam int AGE_W  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic [1:0]  ev_type = 2'b00;
   logic [6:0]  ev_note = 7'd0;
   logic [6:0]  ev_vel = 7'd0;
   logic [27:0] voice_note;
   logic [27:0] voice_vel;
   logic [3:0]  voice_ce;
   logic [6:0]  program_num;
   logic        steal;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   voice_alloc #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_type    (ev_type),
      .ev_note    (ev_note),
      .ev_vel     (ev_vel),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .voice_ce   (voice_ce),
      .program_num(program_num),
      .steal      (steal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  t;
      logic [6:0]  n;
      logic [6:0]  v;
      logic [27:0] en;
      logic [27:0] ev;
      logic [3:0]  ce;
      logic [6:0]  prog;
      logic        st;
   } vec_t;

   vec_t vt[15];

   function automatic logic [27:0] pk(input int a0, input int a1, input int a2, input int a3);
      pk = {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Sends one event and leaves time just after the edge where outputs update.
   task automatic send(input logic [1:0] t, input logic [6:0] n, input logic [6:0] v);
      int  w;
      logic rdy_bad;
      w = 0;
      @(negedge clk);
      while (!ev_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", {31'd0, ev_ready}, 32'd1);
      ev_valid = 1'b1;
      ev_type  = t;
      ev_note  = n;
      ev_vel   = v;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      rdy_bad  = ev_ready;
      for (int k = 0; k < VOICES; k++) begin
         @(posedge clk);
         #1;
         if (ev_ready) rdy_bad = 1'b1;
      end
      chk("ready_low", {31'd0, rdy_bad}, 32'd0);
      @(posedge clk);
      #1;
      chk("ready_back", {31'd0, ev_ready}, 32'd1);
   endtask

   initial begin
      //          type   note    vel     notes v0..v3          vels v0..v3            ce       prog   steal
      vt[0]  = '{2'b01, 7'd60, 7'd100, pk(60, 0, 0, 0),  pk(100, 0, 0, 0),     4'b0001, 7'd0, 1'b0};
      vt[1]  = '{2'b01, 7'd62, 7'd100, pk(60, 62, 0, 0), pk(100, 100, 0, 0),   4'b0011, 7'd0, 1'b0};
      vt[2]  = '{2'b01, 7'd64, 7'd100, pk(60, 62, 64, 0), pk(100, 100, 100, 0), 4'b0111, 7'd0, 1'b0};
      vt[3]  = '{2'b01, 7'd65, 7'd100, pk(60, 62, 64, 65), pk(100, 100, 100, 100), 4'b1111, 7'd0, 1'b0};
      // all busy: oldest is voice 0
      vt[4]  = '{2'b01, 7'd67, 7'd100, pk(67, 62, 64, 65), pk(100, 100, 100, 100), 4'b1111, 7'd0, 1'b1};
      // note-off keeps the note number, velocity field ignored
      vt[5]  = '{2'b00, 7'd64, 7'd33,  pk(67, 62, 64, 65), pk(100, 100, 0, 100),  4'b1011, 7'd0, 1'b0};
      vt[6]  = '{2'b01, 7'd70, 7'd90,  pk(67, 62, 70, 65), pk(100, 100, 90, 100), 4'b1111, 7'd0, 1'b0};
      // retrigger on matching voice
      vt[7]  = '{2'b01, 7'd62, 7'd50,  pk(67, 62, 70, 65), pk(100, 50, 90, 100),  4'b1111, 7'd0, 1'b0};
      // vel 0 note-on acts as note-off
      vt[8]  = '{2'b01, 7'd62, 7'd0,   pk(67, 62, 70, 65), pk(100, 0, 90, 100),   4'b1101, 7'd0, 1'b0};
      vt[9]  = '{2'b10, 7'd5,  7'd77,  pk(67, 62, 70, 65), pk(100, 0, 90, 100),   4'b1101, 7'd5, 1'b0};
      // note-off with no match changes nothing
      vt[10] = '{2'b00, 7'd99, 7'd0,   pk(67, 62, 70, 65), pk(100, 0, 90, 100),   4'b1101, 7'd5, 1'b0};
      vt[11] = '{2'b01, 7'd72, 7'd10,  pk(67, 72, 70, 65), pk(100, 10, 90, 100),  4'b1111, 7'd5, 1'b0};
      // ages now v0=3 v1=0 v2=2 v3=4: voice 3 is oldest
      vt[12] = '{2'b01, 7'd74, 7'd20,  pk(67, 72, 70, 74), pk(100, 10, 90, 20),   4'b1111, 7'd5, 1'b1};
      vt[13] = '{2'b11, 7'd0,  7'd0,   pk(67, 72, 70, 74), pk(0, 0, 0, 0),        4'b0000, 7'd5, 1'b0};
      vt[14] = '{2'b01, 7'd76, 7'd30,  pk(76, 72, 70, 74), pk(30, 0, 0, 0),       4'b0001, 7'd5, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ev_ready}, 32'd1);
      chk("rst_ce", {28'd0, voice_ce}, 32'd0);
      chk("rst_note", {4'd0, voice_note}, 32'd0);
      chk("rst_vel", {4'd0, voice_vel}, 32'd0);
      chk("rst_prog", {25'd0, program_num}, 32'd0);
      chk("rst_steal", {31'd0, steal}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         send(vt[i].t, vt[i].n, vt[i].v);
         chk($sformatf("v%0d_note", i), {4'd0, voice_note}, {4'd0, vt[i].en});
         chk($sformatf("v%0d_vel", i), {4'd0, voice_vel}, {4'd0, vt[i].ev});
         chk($sformatf("v%0d_ce", i), {28'd0, voice_ce}, {28'd0, vt[i].ce});
         chk($sformatf("v%0d_prog", i), {25'd0, program_num}, {25'd0, vt[i].prog});
         chk($sformatf("v%0d_steal", i), {31'd0, steal}, {31'd0, vt[i].st});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_steal_end", i), {31'd0, steal}, 32'd0);
      end

      // reset asserted in the middle of a scan
      @(negedge clk);
      ev_valid = 1'b1;
      ev_type  = 2'b01;
      ev_note  = 7'd80;
      ev_vel   = 7'd80;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ce", {28'd0, voice_ce}, 32'd0);
      chk("mid_rst_prog", {25'd0, program_num}, 32'd0);
      chk("mid_rst_ready", {31'd0, ev_ready}, 32'd1);
      chk("mid_rst_note", {4'd0, voice_note}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(2'b01, 7'd40, 7'd1);
      chk("post_rst_note", {4'd0, voice_note}, {4'd0, pk(40, 0, 0, 0)});
      chk("post_rst_ce", {28'd0, voice_ce}, 32'd1);

      // back-to-back events with ev_valid held high
      begin
         int t[3];
         int n;
         n = 0;
         @(negedge clk);
         ev_valid = 1'b1;
         ev_type  = 2'b10;
         ev_note  = 7'd9;
         ev_vel   = 7'd0;
         for (int k = 0; k < 40 && n < 3; k++) begin
            if (ev_ready) begin
               t[n] = cyc;
               n++;
            end
            @(negedge clk);
         end
         ev_valid = 1'b0;
         chk("b2b_accepts", n, 3);
         if (n == 3) begin
            chk("b2b_gap1", t[1] - t[0], 6);
            chk("b2b_gap2", t[2] - t[1], 6);
         end
         repeat (7) @(negedge clk);
         chk("b2b_prog", {25'd0, program_num}, 32'd9);
         chk("b2b_ce", {28'd0, voice_ce}, 32'd1);
         chk("b2b_ready", {31'd0, ev_ready}, 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
